// File: rtl/signal_pipe_pkg.sv
// Shared types and parameter limits for signal_pipe.
// Holds the per-channel mode encoding and the legal ranges of the top-level parameters.
package signal_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_INV  = 2'd1,
        MODE_ZERO = 2'd2,
        MODE_ONES = 2'd3
    } mode_e;

    localparam int NUM_CHAN_MIN = 1;
    localparam int NUM_CHAN_MAX = 16;
    localparam int WIDTH_MIN    = 1;
    localparam int WIDTH_MAX    = 64;
    localparam int DEPTH_MIN    = 1;
    localparam int DEPTH_MAX    = 8;

endpackage

// File: rtl/signal_pipe_stage.sv
// One valid/ready register slice: holds a single beat plus its valid flag.
// Handshake: a beat moves across an interface on a rising edge where valid and ready are both high.
module signal_pipe_stage #(
    parameter int DataWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o
);

    logic                 valid_q;
    logic [DataWidth-1:0] data_q;

    // An empty slot can always load; a full one can load only when it is draining this cycle.
    assign ready_o = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (ready_o) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_i;
            end
        end
    end

endmodule

// File: rtl/signal_pipe.sv
// Multi-channel per-channel transform followed by a Depth-stage valid/ready pipeline.
// Define SIGNAL_PIPE_STATS_EN to add the 32-bit output beat counter port beat_cnt_o.
module signal_pipe
    import signal_pipe_pkg::*;
#(
    parameter int NumChan = 2,
    parameter int Width   = 8,
    parameter int Depth   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [NumChan*Width-1:0] data_i,
    input  logic [NumChan*2-1:0]     mode_i,
    output logic                     valid_o,
    input  logic                     ready_i,
`ifdef SIGNAL_PIPE_STATS_EN
    output logic [31:0]              beat_cnt_o,
`endif
    output logic [NumChan*Width-1:0] data_o
);

    localparam int DW = NumChan * Width;

    if (Depth < DEPTH_MIN || Depth > DEPTH_MAX) begin : g_bad_depth
        $error("signal_pipe: Depth out of range");
    end
    if (NumChan < NUM_CHAN_MIN || NumChan > NUM_CHAN_MAX) begin : g_bad_chan
        $error("signal_pipe: NumChan out of range");
    end
    if (Width < WIDTH_MIN || Width > WIDTH_MAX) begin : g_bad_width
        $error("signal_pipe: Width out of range");
    end

    logic [DW-1:0] data_xf;

    // Transform is applied before the first stage so stages only carry finished data.
    always_comb begin
        data_xf = '0;
        for (int c = 0; c < NumChan; c++) begin
            case (mode_e'(mode_i[2*c +: 2]))
                MODE_INV:  data_xf[c*Width +: Width] = ~data_i[c*Width +: Width];
                MODE_ZERO: data_xf[c*Width +: Width] = '0;
                MODE_ONES: data_xf[c*Width +: Width] = '1;
                default:   data_xf[c*Width +: Width] = data_i[c*Width +: Width];
            endcase
        end
    end

    for (genvar k = 0; k < Depth; k++) begin : g_stage
        logic          s_valid;
        logic          s_ready;
        logic [DW-1:0] s_data;
        logic          in_valid;
        logic [DW-1:0] in_data;
        logic          out_ready;

        if (k == 0) begin : g_head
            assign in_valid = valid_i;
            assign in_data  = data_xf;
        end else begin : g_link
            assign in_valid = g_stage[k-1].s_valid;
            assign in_data  = g_stage[k-1].s_data;
        end

        if (k == Depth - 1) begin : g_tail
            assign out_ready = ready_i;
        end else begin : g_fwd
            assign out_ready = g_stage[k+1].s_ready;
        end

        signal_pipe_stage #(
            .DataWidth(DW)
        ) u_stage (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .valid_i(in_valid),
            .ready_o(s_ready),
            .data_i (in_data),
            .valid_o(s_valid),
            .ready_i(out_ready),
            .data_o (s_data)
        );
    end

    assign ready_o = g_stage[0].s_ready;
    assign valid_o = g_stage[Depth-1].s_valid;
    assign data_o  = g_stage[Depth-1].s_data;

`ifdef SIGNAL_PIPE_STATS_EN
    logic [31:0] beat_cnt_q;

    // Counts output transfers; wraps naturally at 2^32.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt_q <= '0;
        end else if (valid_o && ready_i) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
        end
    end

    assign beat_cnt_o = beat_cnt_q;
`endif

endmodule

// File: tb/tb_signal_pipe.sv
// Randomized and directed bench for signal_pipe (NumChan=2, Width=8, Depth=2).
// Expected beats are queued at acceptance and checked by an independent output monitor.
module tb_signal_pipe;

    localparam int NumChan = 2;
    localparam int Width   = 8;
    localparam int Depth   = 2;
    localparam int DW      = NumChan * Width;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_i;
    logic [3:0]    mode_i;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] data_o;
`ifdef SIGNAL_PIPE_STATS_EN
    logic [31:0]   beat_cnt_o;
`endif

    signal_pipe #(
        .NumChan(NumChan),
        .Width  (Width),
        .Depth  (Depth)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .mode_i (mode_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
`ifdef SIGNAL_PIPE_STATS_EN
        .beat_cnt_o(beat_cnt_o),
`endif
        .data_o (data_o)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    int            acc_q[$];
    int            n_cmp   = 0;
    int            n_err   = 0;
    int            out_cnt = 0;
    int            n_drive = 0;
    bit            lat_chk = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each channel byte is kept, inverted (255-v), cleared or saturated to 255.
    function automatic logic [DW-1:0] ref_model(input logic [DW-1:0] d, input logic [3:0] m);
        logic [DW-1:0] res;
        int v;
        int r;
        res = '0;
        for (int c = 0; c < NumChan; c++) begin
            v = int'(d[c*Width +: Width]);
            case (int'(m[2*c +: 2]))
                0:       r = v;
                1:       r = 255 - v;
                2:       r = 0;
                default: r = 255;
            endcase
            res = res | (DW'(r) << (Width * c));
        end
        return res;
    endfunction

    // ---------------- monitor ----------------
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d;
    logic [DW-1:0] mon_e;
    int            mon_a;

    always @(negedge clk_i) begin
        if (rst_i) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid_o", 64'(valid_o), 64'd1);
                check("hold_data_o", 64'(data_o), 64'(hold_d));
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data 0x%0h expected no beat (t=%0t)", data_o, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_a = acc_q.pop_front();
                    check("data_o", 64'(data_o), 64'(mon_e));
                    if (lat_chk) check("latency", 64'(cyc - mon_a), 64'(Depth));
                    out_cnt++;
                end
            end
            hold_v = valid_o && !ready_i;
            hold_d = data_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_cycle(input logic v, input logic [DW-1:0] d, input logic [3:0] m,
                               input logic [DW-1:0] e, input logic rdy, output bit acc);
        @(posedge clk_i);
        #1;
        valid_i = v;
        data_i  = d;
        mode_i  = m;
        ready_i = rdy;
        n_drive++;
        @(negedge clk_i);
        acc = v && ready_o;
        if (acc) begin
            exp_q.push_back(e);
            acc_q.push_back(cyc);
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [3:0] m,
                             input logic [DW-1:0] e, input bit rand_rdy);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 200) begin
            drive_cycle(1'b1, d, m, e, rand_rdy ? logic'($urandom_range(0, 1)) : 1'b1, acc);
            tries++;
        end
        if (!acc) check("send_timeout", 64'(tries), 64'd0);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            drive_cycle(1'b0, '0, '0, '0, 1'b1, acc);
            n++;
        end
        drive_cycle(1'b0, '0, '0, '0, 1'b1, acc);
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit            acc;
        int            n_acc;
        int            n0;
        int            o0;
        int            idx;
        logic [DW-1:0] sd[6];
        logic [3:0]    sm[6];
        logic [DW-1:0] d;
        logic [3:0]    m;
        logic          v;

        rst_i   = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        mode_i  = '0;
        ready_i = 1'b0;
        #1;
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_data_o", 64'(data_o), 64'd0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        check("post_rst_ready_o", 64'(ready_o), 64'd1);
        check("post_rst_valid_o", 64'(valid_o), 64'd0);

        // Directed transforms with latency check.
        lat_chk = 1'b1;
        send_beat(16'h3CA5, 4'b0100, 16'hC3A5, 1'b0);
        drain();
        send_beat(16'h1234, 4'b1110, 16'hFF00, 1'b0);
        drain();

        // Back-to-back burst: 10 accepts in 10 cycles, 10 outputs.
        n0 = n_drive;
        o0 = out_cnt;
        for (int i = 0; i < 10; i++) begin
            d = 16'($urandom);
            m = 4'($urandom);
            send_beat(d, m, ref_model(d, m), 1'b0);
        end
        check("b2b_cycles", 64'(n_drive - n0), 64'd10);
        drain();
        check("b2b_outputs", 64'(out_cnt - o0), 64'd10);
        lat_chk = 1'b0;

        // Stall: ready_i low for 5 cycles with continuous input.
        for (int i = 0; i < 6; i++) begin
            sd[i] = 16'($urandom);
            sm[i] = 4'($urandom);
        end
        idx   = 0;
        n_acc = 0;
        for (int s = 0; s < 5; s++) begin
            drive_cycle(1'b1, sd[idx], sm[idx], ref_model(sd[idx], sm[idx]), 1'b0, acc);
            if (acc) begin
                idx++;
                n_acc++;
            end
        end
        check("stall_accepts", 64'(n_acc), 64'(Depth));
        check("stall_ready_o", 64'(ready_o), 64'd0);
        check("stall_valid_o", 64'(valid_o), 64'd1);
        while (idx < 6) begin
            send_beat(sd[idx], sm[idx], ref_model(sd[idx], sm[idx]), 1'b0);
            idx++;
        end
        drain();

        // Reset with two beats in flight.
        send_beat(16'hAAAA, 4'b0000, 16'hAAAA, 1'b0);
        send_beat(16'h5555, 4'b0000, 16'h5555, 1'b0);
        @(posedge clk_i);
        #1;
        check("inflight_valid_o", 64'(valid_o), 64'd1);
        valid_i = 1'b0;
        rst_i   = 1'b1;
        exp_q.delete();
        acc_q.delete();
        #1;
        check("midrst_valid_o", 64'(valid_o), 64'd0);
        check("midrst_data_o", 64'(data_o), 64'd0);
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        check("midrst_ready_o", 64'(ready_o), 64'd1);
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, '0, '0, '0, 1'b1, acc);
        check("after_rst_valid_o", 64'(valid_o), 64'd0);

`ifdef SIGNAL_PIPE_STATS_EN
        o0 = out_cnt;
        for (int i = 0; i < 5; i++) begin
            d = 16'($urandom);
            send_beat(d, 4'b0000, d, 1'b0);
        end
        drain();
        check("beat_cnt", 64'(beat_cnt_o), 64'(out_cnt - o0));
        @(posedge clk_i);
        #1;
        force dut.beat_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.beat_cnt_q;
        send_beat(16'h0101, 4'b0000, 16'h0101, 1'b0);
        drain();
        check("beat_cnt_wrap", 64'(beat_cnt_o), 64'd0);
`endif

        // Random traffic with random gaps and backpressure.
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            d = 16'($urandom);
            m = 4'($urandom);
            drive_cycle(v, d, m, ref_model(d, m),
                        (i < 200) ? logic'($urandom_range(0, 3) != 0) : logic'($urandom_range(0, 3) == 0), acc);
        end
        drain();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/signal_pipe.md
SIGNAL_PIPE -- requirements
Module: signal_pipe

Interface
REQ-001 SHALL provide parameter NumChan, default 2: number of independent data channels, range 1..16.
REQ-002 SHALL provide parameter Width, default 8: bits per channel, range 1..64.
REQ-003 SHALL provide parameter Depth, default 2: register stages between input and output, range 1..8; elaboration error outside range.
REQ-004 SHALL provide clk_i  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL provide rst_i  input  1: reset, asynchronous, active-high.
REQ-006 SHALL provide valid_i  input  1: input beat valid.
REQ-007 SHALL provide ready_o  output  1: block accepts input beat this cycle.
REQ-008 SHALL provide data_i  input  NumChan*Width: channel c occupies bits [c*Width +: Width].
REQ-009 SHALL provide mode_i  input  NumChan*2: per-channel mode, sampled with the beat.
REQ-010 SHALL provide valid_o  output  1: output beat valid.
REQ-011 SHALL provide ready_i  input  1: downstream accepts output beat.
REQ-012 SHALL provide data_o  output  NumChan*Width: transformed data, same channel packing.

Function
REQ-013 SHALL apply per-channel transform at input: mode 0 pass, 1 bitwise invert, 2 all-zero, 3 all-ones.
REQ-014 SHALL transfer a beat on a cycle where valid and ready are both high on the respective side.
REQ-015 SHALL implement Depth chained stages, each holding one beat with a valid flag.
REQ-016 SHALL drive stage k ready as (not stage k valid) or (stage k+1 ready); last stage uses ready_i.
REQ-017 SHALL sustain one beat per cycle when ready_i is held high; no bubbles in steady state.
REQ-018 SHALL deliver an accepted beat on valid_o exactly Depth cycles after acceptance when never stalled.
REQ-019 SHALL hold valid_o and data_o stable while valid_o high and ready_i low.
REQ-020 SHALL not drop, duplicate or reorder beats under any ready_i pattern.
REQ-021 SHALL, when all stages full and ready_i low, drive ready_o low; simultaneous output pop and input push when full SHALL both complete in the same cycle.
REQ-022 SHALL ignore data_i and mode_i on cycles without an input transfer.

Reset
REQ-023 SHALL, on rst_i high, immediately clear all stage valid flags; valid_o low, ready_o high after reset deasserts.
REQ-024 SHALL reset stage data registers to zero; data_o reads zero in reset.
REQ-025 SHALL discard in-flight beats when reset asserts mid-operation; no beat emitted after reset from pre-reset inputs.

Configuration
REQ-026 SHALL compile a beat counter when macro SIGNAL_PIPE_STATS_EN is defined: output beat_cnt_o, 32 bits, increments per output transfer, wraps 0xFFFFFFFF to 0, resets to 0.
REQ-027 SHALL, without SIGNAL_PIPE_STATS_EN, omit beat_cnt_o port and counter logic entirely; all other behaviour identical.

Structure
REQ-028 SHALL place mode enum type (2 bits: PASS, INV, ZERO, ONES) and range limit constants in package signal_pipe_pkg.
REQ-029 SHALL implement one stage as sub-module signal_pipe_stage (valid/ready register slice, parameter DataWidth), instantiated Depth times via generate.

Verification
REQ-030 SHALL cover: NumChan=2, Width=8, Depth=2, ready_i=1, data_i=0x3CA5, mode_i=0b01_00 -> data_o=0xC3A5 with valid_o exactly 2 cycles after acceptance.
REQ-031 SHALL cover: modes 2 and 3 on channels 0/1, data_i=0x1234 -> data_o=0xFF00.
REQ-032 SHALL cover: 10 back-to-back beats, ready_i=1 -> 10 consecutive output cycles, in order, no gaps.
REQ-033 SHALL cover: ready_i=0 for 5 cycles with continuous input -> ready_o low after Depth beats accepted, valid_o/data_o stable; ready_i=1 -> remaining beats drained in order.
REQ-034 SHALL cover: rst_i pulsed while 2 beats in flight -> valid_o low same cycle, no pre-reset beat later emitted.
REQ-035 SHALL cover (with SIGNAL_PIPE_STATS_EN): counter preloaded via 2^32-1 transfers (or forced) -> next transfer yields beat_cnt_o=0.
